// File: rtl/match_scoreboard.sv
// Tic-tac-toe match scoreboard: detects round outcomes from the game-core board, keeps tallies,
// holds the finished board, pulses round_rst back to the core. Optional: AUTO_REMATCH_EN.
module match_scoreboard #(
  parameter int ROUNDS_TO_WIN = 3,
  parameter int HOLD_CYCLES   = 25000000,
  parameter int RST_CYCLES    = 2,
  parameter int SCORE_W       = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [1:0]         a,
  input  logic [1:0]         b,
  input  logic [1:0]         c,
  input  logic [1:0]         d,
  input  logic [1:0]         e,
  input  logic [1:0]         f,
  input  logic [1:0]         g,
  input  logic [1:0]         h,
  input  logic [1:0]         i,
  input  logic [1:0]         winner,
  input  logic               new_match,
  output logic [SCORE_W-1:0] score_p1,
  output logic [SCORE_W-1:0] score_p2,
  output logic [SCORE_W-1:0] draws,
  output logic [1:0]         last_result,
  output logic               hold_active,
  output logic               round_rst,
  output logic               match_over,
  output logic [1:0]         match_winner
);

  typedef enum logic [2:0] {
    ARM  = 3'd0,
    PLAY = 3'd1,
    HOLD = 3'd2,
    RRST = 3'd3,
    DONE = 3'd4
  } state_t;

  localparam logic [1:0] RES_NONE = 2'b00;
  localparam logic [1:0] RES_P1   = 2'b01;
  localparam logic [1:0] RES_P2   = 2'b10;
  localparam logic [1:0] RES_DRAW = 2'b11;

  // One down-counter serves the hold, round-reset and (optionally) rematch timers.
  localparam int CNT_MAX = (HOLD_CYCLES > RST_CYCLES) ? HOLD_CYCLES : RST_CYCLES;
  localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

  localparam logic [CNT_W-1:0]   HOLD_LOAD  = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0]   RST_LOAD   = CNT_W'(RST_CYCLES - 1);
  localparam logic [CNT_W-1:0]   CNT_ONE    = CNT_W'(1);
  localparam logic [SCORE_W-1:0] WIN_SCORE  = SCORE_W'(ROUNDS_TO_WIN);
  localparam logic [SCORE_W-1:0] SCORE_ONE  = SCORE_W'(1);

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [SCORE_W-1:0] score_p1_d, score_p2_d, draws_d;
  logic [1:0]         last_result_d, match_winner_d;
  logic               hold_active_d, round_rst_d, match_over_d;

  logic [8:0][1:0]    cells;
  logic               board_empty, board_full;
  logic               win, draw, rematch;

  assign cells = {i, h, g, f, e, d, c, b, a};

  function automatic logic [SCORE_W-1:0] sat_inc(input logic [SCORE_W-1:0] v);
    return (v == '1) ? v : v + SCORE_ONE;
  endfunction

  always_comb begin
    board_empty = 1'b1;
    board_full  = 1'b1;
    for (int k = 0; k < 9; k++) begin
      if (cells[k] == 2'b00) board_full  = 1'b0;
      else                   board_empty = 1'b0;
    end
  end

  // winner == 11 is neither a win nor allows a draw.
  assign win  = (winner == RES_P1) || (winner == RES_P2);
  assign draw = board_full && (winner == RES_NONE);

  // NOTE: every signal written here gets a default first, so no path leaves one
  // unassigned and no latch is inferred.
  always_comb begin
    state_d        = state_q;
    cnt_d          = cnt_q;
    score_p1_d     = score_p1;
    score_p2_d     = score_p2;
    draws_d        = draws;
    last_result_d  = last_result;
    match_winner_d = match_winner;
    rematch        = 1'b0;

    unique case (state_q)
      ARM: begin
        // Only a cleared board arms detection, so a stale result is never counted twice.
        if (board_empty && (winner == RES_NONE)) state_d = PLAY;
      end

      PLAY: begin
        if (win) begin
          if (winner == RES_P1) score_p1_d = sat_inc(score_p1);
          else                  score_p2_d = sat_inc(score_p2);
          last_result_d = winner;
          cnt_d         = HOLD_LOAD;
          state_d       = HOLD;
        end else if (draw) begin
          draws_d       = sat_inc(draws);
          last_result_d = RES_DRAW;
          cnt_d         = HOLD_LOAD;
          state_d       = HOLD;
        end
      end

      HOLD: begin
        if (cnt_q == '0) begin
          if ((score_p1 >= WIN_SCORE) || (score_p2 >= WIN_SCORE)) begin
            match_winner_d = (score_p1 >= WIN_SCORE) ? RES_P1 : RES_P2;
            state_d        = DONE;
`ifdef AUTO_REMATCH_EN
            cnt_d          = HOLD_LOAD;
`endif
          end else begin
            cnt_d   = RST_LOAD;
            state_d = RRST;
          end
        end else begin
          cnt_d = cnt_q - CNT_ONE;
        end
      end

      RRST: begin
        if (cnt_q == '0) state_d = ARM;
        else             cnt_d   = cnt_q - CNT_ONE;
      end

      DONE: begin
        rematch = new_match;
`ifdef AUTO_REMATCH_EN
        if (cnt_q == '0) rematch = 1'b1;
        else             cnt_d   = cnt_q - CNT_ONE;
`endif
        if (rematch) begin
          score_p1_d     = '0;
          score_p2_d     = '0;
          draws_d        = '0;
          last_result_d  = RES_NONE;
          match_winner_d = RES_NONE;
          cnt_d          = RST_LOAD;
          state_d        = RRST;
        end
      end

      default: state_d = ARM;
    endcase
  end

  // Status flags are decoded from the next state and registered, so they line up
  // with the state and carry no combinational path from the inputs.
  always_comb begin
    hold_active_d = (state_d == HOLD);
    round_rst_d   = (state_d == RRST);
    match_over_d  = (state_d == DONE);
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ARM;
      cnt_q        <= '0;
      score_p1     <= '0;
      score_p2     <= '0;
      draws        <= '0;
      last_result  <= RES_NONE;
      match_winner <= RES_NONE;
      hold_active  <= 1'b0;
      round_rst    <= 1'b0;
      match_over   <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      score_p1     <= score_p1_d;
      score_p2     <= score_p2_d;
      draws        <= draws_d;
      last_result  <= last_result_d;
      match_winner <= match_winner_d;
      hold_active  <= hold_active_d;
      round_rst    <= round_rst_d;
      match_over   <= match_over_d;
    end
  end

endmodule

// File: tb/tb_match_scoreboard.sv
// Self-checking bench for match_scoreboard: directed scenarios plus random board traffic,
// all outputs compared every cycle against a behavioural model of the round/match rules.
module tb_match_scoreboard;

  localparam int HOLD = 4;
  localparam int RSTC = 2;
  localparam int RTW  = 2;
  localparam int SW   = 4;
  localparam int SMAX = (1 << SW) - 1;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic [8:0][1:0] cells = '0;
  logic [1:0]      winner = 2'b00;
  logic            new_match = 1'b0;

  logic [SW-1:0]   score_p1, score_p2, draws;
  logic [1:0]      last_result, match_winner;
  logic            hold_active, round_rst, match_over;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  match_scoreboard #(
    .ROUNDS_TO_WIN(RTW),
    .HOLD_CYCLES  (HOLD),
    .RST_CYCLES   (RSTC),
    .SCORE_W      (SW)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .a           (cells[0]),
    .b           (cells[1]),
    .c           (cells[2]),
    .d           (cells[3]),
    .e           (cells[4]),
    .f           (cells[5]),
    .g           (cells[6]),
    .h           (cells[7]),
    .i           (cells[8]),
    .winner      (winner),
    .new_match   (new_match),
    .score_p1    (score_p1),
    .score_p2    (score_p2),
    .draws       (draws),
    .last_result (last_result),
    .hold_active (hold_active),
    .round_rst   (round_rst),
    .match_over  (match_over),
    .match_winner(match_winner)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // Phase plus "cycles remaining" in the current timed phase.
  typedef enum int {M_ARM, M_PLAY, M_HOLD, M_RRST, M_DONE} phase_t;

  phase_t ph     = M_ARM;
  int     left   = 0;
  int     m_p1   = 0;
  int     m_p2   = 0;
  int     m_dr   = 0;
  int     m_last = 0;
  int     m_mw   = 0;

  function automatic int bump(input int v);
    return (v < SMAX) ? v + 1 : v;
  endfunction

  always @(posedge clk) begin
    phase_t p;
    int l, p1, p2, dr, last, mw;
    bit emp, full, rematch;
    p = ph; l = left; p1 = m_p1; p2 = m_p2; dr = m_dr; last = m_last; mw = m_mw;
    emp = 1'b1; full = 1'b1;
    for (int k = 0; k < 9; k++) begin
      if (cells[k] == 2'b00) full = 1'b0;
      else                   emp  = 1'b0;
    end
    if (rst) begin
      p = M_ARM; l = 0; p1 = 0; p2 = 0; dr = 0; last = 0; mw = 0;
    end else begin
      case (p)
        M_ARM: if (emp && winner == 2'b00) p = M_PLAY;
        M_PLAY: begin
          if (winner == 2'b01 || winner == 2'b10) begin
            if (winner == 2'b01) p1 = bump(p1);
            else                 p2 = bump(p2);
            last = int'(winner); l = HOLD; p = M_HOLD;
          end else if (full && winner == 2'b00) begin
            dr = bump(dr); last = 3; l = HOLD; p = M_HOLD;
          end
        end
        M_HOLD: begin
          l--;
          if (l == 0) begin
            if (p1 >= RTW || p2 >= RTW) begin
              p = M_DONE; mw = (p1 >= RTW) ? 1 : 2; l = HOLD;
            end else begin
              p = M_RRST; l = RSTC;
            end
          end
        end
        M_RRST: begin
          l--;
          if (l == 0) p = M_ARM;
        end
        M_DONE: begin
          rematch = new_match;
`ifdef AUTO_REMATCH_EN
          l--;
          if (l == 0) rematch = 1'b1;
`endif
          if (rematch) begin
            p1 = 0; p2 = 0; dr = 0; last = 0; mw = 0; p = M_RRST; l = RSTC;
          end
        end
        default: p = M_ARM;
      endcase
    end
    ph <= p; left <= l; m_p1 <= p1; m_p2 <= p2; m_dr <= dr; m_last <= last; m_mw <= mw;
  end

  // Per-cycle compare, away from the active edge.
  always @(negedge clk) begin
    check("score_p1",     score_p1,     m_p1);
    check("score_p2",     score_p2,     m_p2);
    check("draws",        draws,        m_dr);
    check("last_result",  last_result,  m_last);
    check("match_winner", match_winner, m_mw);
    check("hold_active",  hold_active,  ph == M_HOLD);
    check("round_rst",    round_rst,    ph == M_RRST);
    check("match_over",   match_over,   ph == M_DONE);
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  function automatic logic [8:0][1:0] full_alt();
    logic [8:0][1:0] r;
    for (int k = 0; k < 9; k++) r[k] = (k % 2 == 1) ? 2'b10 : 2'b01;
    return r;
  endfunction

  function automatic logic sig(input int which);
    case (which)
      0:       return hold_active;
      1:       return round_rst;
      default: return match_over;
    endcase
  endfunction

  // Length of the high run starting at (or shortly after) the current negedge; bounded.
  task automatic count_high(input int which, output int n);
    n = 0;
    for (int k = 0; k < 40; k++) begin
      if (sig(which)) n++;
      else if (n > 0) break;
      @(negedge clk);
    end
  endtask

  // From ARM: arm on an empty board, then present one result for a single cycle.
  task automatic play_result(input logic [1:0] w, input bit full_board);
    cells = '0; winner = 2'b00;
    tick(1);
    if (full_board) cells = full_alt();
    winner = w;
    tick(1);
    winner = 2'b00;
  endtask

  initial begin
    int n;

    // 1. reset, then PLAY one cycle after release
    tick(3);
    check("reset outputs",
          {score_p1, score_p2, draws, last_result, hold_active, round_rst, match_over, match_winner}, 0);
    rst = 1'b0;
    tick(1);
    check("armed outputs",
          {score_p1, score_p2, draws, last_result, hold_active, round_rst, match_over, match_winner}, 0);

    // 2. p1 win: hold 4 cycles, round_rst 2 cycles
    winner = 2'b01;
    tick(1);
    winner = 2'b00;
    check("s2 score_p1", score_p1, 1);
    check("s2 last_result", last_result, 2'b01);
    check("s2 hold_active", hold_active, 1);
    count_high(0, n); check("s2 hold cycles", n, HOLD);
    count_high(1, n); check("s2 rrst cycles", n, RSTC);

    // 3. draw on a full board, then p2 win on a full board (win beats draw)
    play_result(2'b00, 1'b1);
    check("s3 draws", draws, 1);
    check("s3 last_result", last_result, 2'b11);
    check("s3 scores", {score_p1, score_p2}, {4'd1, 4'd0});
    count_high(0, n); check("s3 hold cycles", n, HOLD);
    count_high(1, n);
    tick(3);
    check("s3 stale full board", {draws, hold_active}, {4'd1, 1'b0});
    play_result(2'b10, 1'b1);
    check("s3 score_p2", score_p2, 1);
    check("s3 draws kept", draws, 1);
    check("s3 last p2", last_result, 2'b10);
    count_high(0, n);
    count_high(1, n);

    // 4. winning board left in place: no recount while armed
    tick(5);
    check("s4 no double count", score_p2, 1);
    check("s4 idle", {hold_active, round_rst}, 2'b00);

    // 5. p2 takes the match, then new_match
    play_result(2'b10, 1'b0);
    check("s5 score_p2", score_p2, 2);
    count_high(0, n); check("s5 hold cycles", n, HOLD);
    check("s5 match_over", match_over, 1);
    check("s5 match_winner", match_winner, 2'b10);
    check("s5 no round_rst", round_rst, 0);
    winner = 2'b01;
    tick(2);
    winner = 2'b00;
    check("s5 frozen", {score_p1, score_p2, match_over}, {4'd1, 4'd2, 1'b1});
    new_match = 1'b1;
    tick(1);
    new_match = 1'b0;
    check("s5 cleared", {score_p1, score_p2, draws, last_result, match_over, match_winner}, 0);
    check("s5 round_rst", round_rst, 1);
    count_high(1, n); check("s5 rrst cycles", n, RSTC);

`ifdef AUTO_REMATCH_EN
    play_result(2'b01, 1'b0);
    count_high(0, n);
    count_high(1, n);
    play_result(2'b01, 1'b0);
    count_high(0, n);
    count_high(2, n); check("auto done cycles", n, HOLD);
    check("auto cleared", {score_p1, round_rst}, {4'd0, 1'b1});
    count_high(1, n);
`endif

    // 6. rst in the second HOLD cycle
    play_result(2'b01, 1'b0);
    tick(1);
    check("s6 in hold", hold_active, 1);
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
    check("s6 reset outputs",
          {score_p1, score_p2, draws, last_result, hold_active, round_rst, match_over, match_winner}, 0);

    // draws saturate within a match
    for (int r = 0; r < SMAX + 2; r++) begin
      play_result(2'b00, 1'b1);
      count_high(0, n);
      count_high(1, n);
    end
    check("draw saturation", draws, SMAX);
    check("draw sat scores", {score_p1, score_p2}, 0);

    // random traffic
    for (int cyc = 0; cyc < 4000; cyc++) begin
      int sel;
      sel = $urandom_range(0, 9);
      if (sel < 4) begin
        cells  = '0;
        winner = ($urandom_range(0, 3) == 0) ? 2'($urandom) : 2'b00;
      end else if (sel < 7) begin
        for (int k = 0; k < 9; k++) cells[k] = 2'($urandom_range(1, 3));
        winner = ($urandom_range(0, 1) == 0) ? 2'b00 : 2'($urandom);
      end else begin
        for (int k = 0; k < 9; k++) cells[k] = 2'($urandom);
        winner = 2'($urandom);
      end
      new_match = ($urandom_range(0, 15) == 0);
      rst       = ($urandom_range(0, 599) == 0);
      tick(1);
    end
    rst = 1'b0; new_match = 1'b0;
    tick(2);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
